sw_debounce: RTL and testbench
==============================

# sw_debounce

Upstream conditioning stage for the Basys3 slide switches. Synchronises each of the WIDTH asynchronous switch inputs into the `clk` domain and filters contact bounce. Presents a clean, registered switch bus that the LED output stage consumes directly in place of raw `sw`. Optionally emits one-cycle rise/fall pulses per switch.

## Interface
- `WIDTH`, 16: number of switch channels.
- `STABLE_CYCLES`, 1000000: consecutive cycles a new level must persist before acceptance; 10 ms at 100 MHz. Legal range ≥ 2.
- `clk`  input  1  100 MHz board clock; all state on the rising edge.
- `rst`  input  1  reset, asynchronous assert, active-high; synchronous deassert handled outside.
- `sw`  input  WIDTH  raw switch levels, asynchronous to `clk`.
- `sw_db`  output  WIDTH  debounced switch levels (registered).
- `sw_rise`  output  WIDTH  one-cycle pulse when `sw_db[i]` goes 0→1 (only with `SW_DEBOUNCE_EDGE_EN`).
- `sw_fall`  output  WIDTH  one-cycle pulse when `sw_db[i]` goes 1→0 (only with `SW_DEBOUNCE_EDGE_EN`).

## Operation
- Each channel is independent and identical; no cross-channel interaction.
- Synchroniser: two flops per channel, `s1 <= sw[i]`, `s2 <= s1`. `s2` is the only value the filter sees.
- Filter state per channel: `cnt` (width `$clog2(STABLE_CYCLES)`), `sw_db[i]`.
  - `s2 == sw_db[i]`: `cnt <= 0`.
  - `s2 != sw_db[i]` and `cnt < STABLE_CYCLES-1`: `cnt <= cnt+1`.
  - `s2 != sw_db[i]` and `cnt == STABLE_CYCLES-1`: `sw_db[i] <= s2`, `cnt <= 0`.
- Any single cycle where `s2` matches `sw_db[i]` clears `cnt`. A bounce restarts the full window. No partial credit.
- The counter never exceeds `STABLE_CYCLES-1`. There is no wrap-around.
- Edge pulses are registered. `sw_rise[i] <= accept & s2`, `sw_fall[i] <= accept & ~s2`, where `accept` is the third filter condition. Pulses are therefore high in the same cycle the new `sw_db[i]` value first appears.
- Pulses last exactly one cycle. Rise and fall on the same channel are mutually exclusive.
- Reset: `s1`, `s2`, `cnt`, `sw_db`, `sw_rise` and `sw_fall` all clear to 0.
  - Reset mid-count discards progress.
  - A switch held high through reset produces `sw_db=1` and a `sw_rise` pulse `STABLE_CYCLES+2` edges after release.

## Timing
- Latency: a level first sampled by `s1` at rising edge k appears on `sw_db` at edge k+1+STABLE_CYCLES, i.e. `STABLE_CYCLES+2` edges counting edge k.
- The input must be stable for `STABLE_CYCLES` consecutive `s2` samples.
- A glitch shorter than `STABLE_CYCLES` cycles never reaches `sw_db`.
- No handshake. Outputs are valid every cycle.
- Throughput: one accepted transition per channel per `STABLE_CYCLES` cycles at most.

## Configuration
- Macro: `SW_DEBOUNCE_EDGE_EN`.
- Defined: the `sw_rise`/`sw_fall` ports and their registers exist as described.
- Undefined: both ports are absent from the port list and no edge logic is generated. `sw_db` behaviour is identical in both builds.

## Structure
- Shared package `led_project_pkg`:
  - `SW_WIDTH = 16`
  - `CLK_HZ = 100_000_000`
  - `DEBOUNCE_MS = 10`
  - derived `DEBOUNCE_CYCLES`
- Sub-module `sw_debounce_chan` holds one channel: synchroniser, counter, `sw_db` bit and edge bits. The top level is a generate loop of WIDTH instances.

## Test plan
Bench runs with `STABLE_CYCLES=4`, `WIDTH=16`, edge build unless noted.
- Reset: assert `rst` with `sw=16'hFFFF` → `sw_db=0`, `sw_rise=0`, `sw_fall=0` while asserted. After release, `sw_db=16'hFFFF` exactly 6 edges later, with a `sw_rise=16'hFFFF` pulse of exactly one cycle.
- Clean step: `sw[3]` 0→1 before edge k → `sw_db[3]` rises at edge k+5 and `sw_rise[3]` is high for one cycle. All other bits remain 0.
- Bounce: `sw[0]` toggles 1,0,1 with 2-cycle dwell each, then holds 1 → `sw_db[0]` rises only 4 `s2` cycles after the final 1. There is exactly one `sw_rise[0]` pulse and no `sw_fall[0]` pulse.
- Short glitch: `sw[15]` high for 3 cycles then low → `sw_db[15]` and `sw_rise[15]` stay 0 throughout.
- Independence and mid-count reset:
  - `sw=16'hA5A5` in one cycle → `sw_db=16'hA5A5` after 6 edges.
  - Repeat with `rst` pulsed 2 cycles into the window → `sw_db` stays 0 until 6 edges after reset release.
- Macro-off build: compiles without `sw_rise`/`sw_fall`, and the clean-step scenario gives the same `sw_db` timing.

Source files
------------

// File: rtl/led_project_pkg.sv
// ---------------------------------------------------------------------------
// led_project_pkg
//   Shared constants for the Basys3 switch/LED project, plus the small types
//   and helpers used by the switch debounce block.
//
//   SW_WIDTH        number of slide switches on the board
//   CLK_HZ          board clock frequency
//   DEBOUNCE_MS     required quiet time before a new switch level is accepted
//   DEBOUNCE_CYCLES DEBOUNCE_MS expressed in clk cycles
// ---------------------------------------------------------------------------
package led_project_pkg;

  localparam int SW_WIDTH        = 16;
  localparam int CLK_HZ          = 100_000_000;
  localparam int DEBOUNCE_MS     = 10;
  localparam int DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

  // Per-cycle decision taken by one filter channel.
  typedef enum logic [1:0] {
    FILT_MATCH  = 2'd0,  // synchronised level equals the debounced level
    FILT_COUNT  = 2'd1,  // level differs, window not yet complete
    FILT_ACCEPT = 2'd2   // level differed for the whole window; take it
  } filt_act_e;

  // Counter width for a window of n cycles; the counter only has to hold
  // 0 .. n-1, and never less than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/sw_debounce_chan.sv
// ---------------------------------------------------------------------------
// sw_debounce_chan
//   One switch channel: two-flop synchroniser followed by a bounce filter
//   that only accepts a new level after it has been seen on every one of
//   STABLE_CYCLES consecutive synchronised samples.
//
//   Build option: SW_DEBOUNCE_EDGE_EN adds registered one-cycle rise/fall
//   pulses that coincide with the first cycle of the new sw_db value.
//
//   Ports
//     clk      board clock, all state on the rising edge
//     rst      asynchronous active-high reset
//     sw       raw switch level, asynchronous to clk
//     sw_db    debounced switch level (registered)
//     sw_rise  pulse on sw_db 0->1   (SW_DEBOUNCE_EDGE_EN only)
//     sw_fall  pulse on sw_db 1->0   (SW_DEBOUNCE_EDGE_EN only)
// ---------------------------------------------------------------------------
module sw_debounce_chan
  import led_project_pkg::*;
#(
  parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic sw_db
`ifdef SW_DEBOUNCE_EDGE_EN
  ,
  output logic sw_rise,
  output logic sw_fall
`endif
);

  localparam int            CW       = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  filt_act_e     act;

  // Synchroniser; s2 is the only copy of the switch the filter looks at.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sw;
      s2 <= s1;
    end
  end

  // Any agreeing sample takes priority, so a single bounce back to the
  // current level throws away the whole partial window.
  always_comb begin
    act = FILT_COUNT;
    if (s2 == sw_db) begin
      act = FILT_MATCH;
    end else if (cnt == CNT_LAST) begin
      act = FILT_ACCEPT;
    end
  end

  // The counter stops at CNT_LAST and is cleared on acceptance, so it can
  // never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      sw_db <= 1'b0;
    end else begin
      case (act)
        FILT_MATCH: begin
          cnt <= '0;
        end
        FILT_COUNT: begin
          cnt <= cnt + CNT_ONE;
        end
        FILT_ACCEPT: begin
          cnt   <= '0;
          sw_db <= s2;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

`ifdef SW_DEBOUNCE_EDGE_EN
  // Registered from the same accept decision as sw_db, so a pulse is high
  // exactly in the first cycle the new level is visible. Rise and fall
  // cannot coincide because they take opposite polarities of s2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
    end else begin
      sw_rise <= (act == FILT_ACCEPT) &  s2;
      sw_fall <= (act == FILT_ACCEPT) & ~s2;
    end
  end
`endif

endmodule

// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
//   Conditioning stage for the Basys3 slide switches. Each of the WIDTH
//   asynchronous inputs is synchronised into clk and bounce-filtered by an
//   independent sw_debounce_chan; the LED stage uses sw_db instead of raw sw.
//
//   Build option: SW_DEBOUNCE_EDGE_EN adds the sw_rise/sw_fall pulse ports.
//   Without it those ports do not exist and no edge logic is built; sw_db
//   behaves identically in both builds.
//
//   Parameters
//     WIDTH          number of switch channels
//     STABLE_CYCLES  samples a new level must persist before acceptance (>= 2)
//
//   Ports
//     clk      100 MHz board clock
//     rst      asynchronous active-high reset (deassert synchronised outside)
//     sw       raw switch levels
//     sw_db    debounced switch levels
//     sw_rise  per-channel one-cycle pulse on sw_db 0->1 (edge build only)
//     sw_fall  per-channel one-cycle pulse on sw_db 1->0 (edge build only)
// ---------------------------------------------------------------------------
module sw_debounce
  import led_project_pkg::*;
#(
  parameter int WIDTH         = SW_WIDTH,
  parameter int STABLE_CYCLES = DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_db
`ifdef SW_DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sw_debounce_chan #(
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .sw      (sw[i]),
      .sw_db   (sw_db[i])
`ifdef SW_DEBOUNCE_EDGE_EN
      ,
      .sw_rise (sw_rise[i]),
      .sw_fall (sw_fall[i])
`endif
    );
  end

endmodule

// File: tb/tb_sw_debounce.sv
// ---------------------------------------------------------------------------
// tb_sw_debounce
//   Self-checking bench for sw_debounce with WIDTH=16, STABLE_CYCLES=4.
//   Works in both builds; pulse checks exist only with SW_DEBOUNCE_EDGE_EN.
// ---------------------------------------------------------------------------
module tb_sw_debounce;

  localparam int W = 16;
  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] sw;
  logic [W-1:0] sw_db;
`ifdef SW_DEBOUNCE_EDGE_EN
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  sw_debounce #(
    .WIDTH         (W),
    .STABLE_CYCLES (N)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw      (sw),
    .sw_db   (sw_db)
`ifdef SW_DEBOUNCE_EDGE_EN
    ,
    .sw_rise (sw_rise),
    .sw_fall (sw_fall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last N samples seen by
  // the filter (the raw input delayed two edges) all differ from the
  // current debounced value, counting only samples taken since reset.
  logic [W-1:0] m_p1, m_p2, m_db, m_rise, m_fall;
  logic [W-1:0] hist[$];

  task automatic model_step();
    logic [W-1:0] seen;
    logic [W-1:0] acc;
    if (rst) begin
      m_p1 = '0; m_p2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
      hist.delete();
    end else begin
      seen = m_p2;
      hist.push_back(seen);
      if (hist.size() > N) void'(hist.pop_front());
      acc = '0;
      if (hist.size() == N) begin
        acc = '1;
        foreach (hist[j]) acc = acc & (hist[j] ^ m_db);
      end
      m_rise = acc & seen;
      m_fall = acc & ~seen;
      m_db   = (m_db & ~acc) | (seen & acc);
      m_p2   = m_p1;
      m_p1   = sw;
    end
  endtask

  // One clock: model advances at the edge, DUT sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic reset_idle();
    sw  = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
  endtask

  typedef struct {
    logic [W-1:0] sw;
    logic [W-1:0] db;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic [W-1:0] s, input logic [W-1:0] d,
                     input logic [W-1:0] r, input logic [W-1:0] f);
    vec_t v;
    v.sw = s; v.db = d; v.rise = r; v.fall = f;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1;
    sw  = 16'hFFFF;

    // Reset held with all switches high, then release.
    tick(); tick(); tick();
    chk("reset_db", sw_db, 16'h0000);
`ifdef SW_DEBOUNCE_EDGE_EN
    chk("reset_rise", sw_rise, 16'h0000);
    chk("reset_fall", sw_fall, 16'h0000);
`endif
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("rel_db_e%0d", e), sw_db, (e >= 6) ? 16'hFFFF : 16'h0000);
`ifdef SW_DEBOUNCE_EDGE_EN
      chk($sformatf("rel_rise_e%0d", e), sw_rise, (e == 6) ? 16'hFFFF : 16'h0000);
`endif
    end

    // Clean step on sw[3], bounce on sw[0], glitch on sw[15], release sw[3].
    add(5, 16'h0008, 16'h0000, 16'h0000, 16'h0000);
    add(1, 16'h0008, 16'h0008, 16'h0008, 16'h0000);
    add(1, 16'h0008, 16'h0008, 16'h0000, 16'h0000);
    add(2, 16'h0009, 16'h0008, 16'h0000, 16'h0000);
    add(2, 16'h0008, 16'h0008, 16'h0000, 16'h0000);
    add(5, 16'h0009, 16'h0008, 16'h0000, 16'h0000);
    add(1, 16'h0009, 16'h0009, 16'h0001, 16'h0000);
    add(1, 16'h0009, 16'h0009, 16'h0000, 16'h0000);
    add(3, 16'h8009, 16'h0009, 16'h0000, 16'h0000);
    add(6, 16'h0009, 16'h0009, 16'h0000, 16'h0000);
    add(5, 16'h0001, 16'h0009, 16'h0000, 16'h0000);
    add(1, 16'h0001, 16'h0001, 16'h0000, 16'h0008);
    add(1, 16'h0001, 16'h0001, 16'h0000, 16'h0000);

    reset_idle();
    foreach (vecs[i]) begin
      sw = vecs[i].sw;
      tick();
      chk($sformatf("vec%0d_db", i), sw_db, vecs[i].db);
`ifdef SW_DEBOUNCE_EDGE_EN
      chk($sformatf("vec%0d_rise", i), sw_rise, vecs[i].rise);
      chk($sformatf("vec%0d_fall", i), sw_fall, vecs[i].fall);
`endif
    end

    // All channels at once.
    reset_idle();
    sw = 16'hA5A5;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk($sformatf("a5_db_e%0d", e), sw_db, (e == 6) ? 16'hA5A5 : 16'h0000);
    end

    // Reset two cycles into the window discards the progress.
    reset_idle();
    sw = 16'hA5A5;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("midrst_db_a", sw_db, 16'h0000);
    tick();
    chk("midrst_db_b", sw_db, 16'h0000);
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk($sformatf("midrst_db_r%0d", e), sw_db, (e == 6) ? 16'hA5A5 : 16'h0000);
    end

    // Random toggling with occasional resets against the model.
    reset_idle();
    for (int c = 0; c < 600; c++) begin
      logic [W-1:0] flip;
      tick();
      chk("rand_db", sw_db, m_db);
`ifdef SW_DEBOUNCE_EDGE_EN
      chk("rand_rise", sw_rise, m_rise);
      chk("rand_fall", sw_fall, m_fall);
`endif
      flip = '0;
      for (int b = 0; b < W; b++) flip[b] = ($urandom_range(5) == 0);
      if ($urandom_range(3) == 0) flip = '0;
      sw = sw ^ flip;
      if (rst) rst = 1'b0;
      else if ($urandom_range(149) == 0) rst = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
